// File: rtl/shift_chain_sched.sv
// rtl/shift_chain_sched.sv - serialise a pattern through a DEPTH-stage 1-bit chain and recapture it
//
// Sequencer for a DEPTH-stage non-blocking 1-bit register chain. An accepted
// start latches the pattern. The pattern is shifted in LSB first and the
// chain is then drained with zeros. Bits leaving the last stage are
// reassembled into a capture word.
//
// Parameters:
//   DEPTH   number of chain stages (>=1)
//   PAT_W   pattern length in bits (>=1)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          begin a run; sampled only in IDLE
//   abort          cancel a run in progress (SHIFT/DRAIN only)
//   pattern        word to serialise; latched on accepted start
//   stage_q        chain contents; bit 0 = first stage, bit DEPTH-1 = last stage
//   busy           high in SHIFT or DRAIN
//   done           one-cycle pulse in DONE
//   capture        reassembled word; valid while done=1, held until next start
//
// Optional feature (macro SHIFT_CHAIN_COLLAPSE_MON_EN):
//   collapsed_q    chain as if written with blocking assignments
//   diverge_cnt    saturating count of edges where the collapsed and true last
//                  stages disagree

module shift_chain_sched #(
  parameter int DEPTH = 3,
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  output logic [DEPTH-1:0] stage_q,
  output logic             busy,
  output logic             done,
  output logic [PAT_W-1:0] capture
`ifdef SHIFT_CHAIN_COLLAPSE_MON_EN
  ,
  output logic [DEPTH-1:0] collapsed_q,
  output logic [7:0]       diverge_cnt
`endif
);

  localparam int CW = $clog2(PAT_W + DEPTH + 1);

  // Edge indices, measured from the first edge after entering SHIFT
  localparam logic [CW-1:0] C_SHIFT_LAST = CW'(PAT_W - 1);
  localparam logic [CW-1:0] C_DRAIN_LAST = CW'(PAT_W + DEPTH - 1);
  localparam logic [CW-1:0] C_CAP_FIRST  = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [PAT_W-1:0] r_pat;
  logic [CW-1:0]    r_cnt;
  logic [DEPTH-1:0] r_stage_q;
  logic [PAT_W-1:0] r_capture;

  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic             w_advance;
  logic             w_abort_run;
  logic             w_pat_bit;
  logic             w_serial_in;
  logic [DEPTH-1:0] w_stage_nxt;
  logic [PAT_W-1:0] w_cap_nxt;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // abort overrides the SHIFT->DRAIN and DRAIN->DONE transitions.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == C_SHIFT_LAST) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == C_DRAIN_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    w_abort_run = 1'b0;
    w_serial_in = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = start;
      end
      S_SHIFT: begin
        w_busy      = 1'b1;
        w_advance   = ~abort;
        w_abort_run = abort;
        w_serial_in = w_pat_bit;
      end
      S_DRAIN: begin
        w_busy      = 1'b1;
        w_advance   = ~abort;
        w_abort_run = abort;
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Bit j of the latched pattern. In SHIFT, r_cnt is always below PAT_W.
  assign w_pat_bit = |(r_pat & (PAT_W'(1) << r_cnt));

  // Next chain and capture values. Degenerate widths are split out so that
  // no zero-width or reversed slice is ever elaborated.
  generate
    if (DEPTH == 1) begin : g_stage_d1
      assign w_stage_nxt = w_serial_in;
    end else begin : g_stage_dn
      assign w_stage_nxt = {r_stage_q[DEPTH-2:0], w_serial_in};
    end

    if (PAT_W == 1) begin : g_cap_w1
      assign w_cap_nxt = r_stage_q[DEPTH-1];
    end else begin : g_cap_wn
      assign w_cap_nxt = {r_stage_q[DEPTH-1], r_capture[PAT_W-1:1]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Datapath: pattern latch, edge counter, chain, capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat     <= '0;
      r_cnt     <= '0;
      r_stage_q <= '0;
      r_capture <= '0;
    end else if (w_accept) begin
      r_pat     <= pattern;
      r_cnt     <= '0;
      r_capture <= '0;
    end else if (w_advance) begin
      r_stage_q <= w_stage_nxt;
      r_cnt     <= r_cnt + CW'(1);
      // The first DEPTH edges only fill the chain. After that, each edge
      // pulls one pattern bit off the last stage, MSB end first.
      if (r_cnt >= C_CAP_FIRST) begin
        r_capture <= w_cap_nxt;
      end
    end else if (w_abort_run) begin
      // Flush the chain. The partial capture stays visible.
      r_stage_q <= '0;
    end
  end

  assign stage_q = r_stage_q;
  assign busy    = w_busy;
  assign done    = w_done;
  assign capture = r_capture;

`ifdef SHIFT_CHAIN_COLLAPSE_MON_EN
  // ---------------------------------------------------------------------------
  // Collapse monitor. With blocking assignments, every stage takes serial_in
  // on the same edge. Each edge where that model's last stage differs from
  // the real chain's last stage is counted.
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] r_collapsed_q;
  logic [7:0]       r_diverge_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_collapsed_q <= '0;
      r_diverge_cnt <= '0;
    end else if (w_accept) begin
      r_collapsed_q <= '0;
      r_diverge_cnt <= '0;
    end else if (w_advance) begin
      r_collapsed_q <= {DEPTH{w_serial_in}};
      if ((w_serial_in != w_stage_nxt[DEPTH-1]) && (r_diverge_cnt != 8'hFF)) begin
        r_diverge_cnt <= r_diverge_cnt + 8'd1;
      end
    end
  end

  assign collapsed_q = r_collapsed_q;
  assign diverge_cnt = r_diverge_cnt;
`endif

endmodule

// File: doc/shift_chain_sched.md
Name: shift_chain_sched

Overview:
Sequencer for a DEPTH-stage, 1-bit, non-blocking register chain. It serialises a parallel pattern into the chain LSB first, then drains the chain. It reassembles the bits leaving the last stage into a capture word. A bench or upstream controller uses it to prove that the chain's end-to-end latency is exactly DEPTH cycles and that the pattern arrives intact.

Parameters:
DEPTH, 3, number of chain stages (>=1)
PAT_W, 8, pattern length in bits (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a run; sampled only in IDLE
abort  input  1  cancel a run in progress
pattern  input  PAT_W  word to serialise; latched on accepted start
stage_q  output  DEPTH  chain contents; bit 0 = first stage, bit DEPTH-1 = last stage
busy  output  1  high in SHIFT or DRAIN
done  output  1  one-cycle pulse in DONE
capture  output  PAT_W  reassembled word; valid while done=1, held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset (async, any state): state=IDLE; stage_q, capture, internal pattern register and counter all 0; busy=0; done=0.
- FSM states: IDLE, SHIFT, DRAIN, DONE. Encoding is free.
- IDLE:
  - start=1 -> latch pattern into pat_r, clear capture, cnt<=0, go to SHIFT.
  - start=0 -> stay in IDLE; stage_q is held.
- Shift edges: edges after entering SHIFT are numbered j=0,1,2,... cnt tracks j. cnt width is $clog2(PAT_W+DEPTH+1).
- Chain update on every SHIFT/DRAIN edge:
  - stage_q[0] <= serial_in.
  - stage_q[i] <= stage_q[i-1] for i>0 (true non-blocking shift).
  - serial_in = pat_r[j] in SHIFT, 0 in DRAIN.
- SHIFT covers j=0..PAT_W-1. At j=PAT_W-1 go to DRAIN.
- DRAIN covers j=PAT_W..PAT_W+DEPTH-1. At j=PAT_W+DEPTH-1 go to DONE.
- Capture rule:
  - On any SHIFT/DRAIN edge with j>=DEPTH: capture <= {stage_q[DEPTH-1], capture[PAT_W-1:1]}.
  - Bit k of pat_r therefore lands after edge j=k+DEPTH.
  - After the final edge, capture == pat_r.
- DONE: done=1 for exactly one cycle, busy=0. Next edge goes to IDLE unconditionally; a start during DONE is ignored.
- Latency: start accepted at edge E0 -> done high in the cycle after edge E0+PAT_W+DEPTH. busy is high for PAT_W+DEPTH cycles.
- start while busy or in DONE: ignored; pattern changes are ignored.
- abort=1 in SHIFT or DRAIN:
  - Next edge: IDLE, stage_q cleared to 0, done is not pulsed, capture holds its partial value.
  - abort in IDLE or DONE has no effect.
  - abort has priority over the SHIFT->DRAIN and DRAIN->DONE transitions.
- abort and start both high in IDLE: start wins.
- Reset asserted mid-run: immediate return to all reset values; no done pulse.
- Degenerate DEPTH=1 and PAT_W=1 must work with the same formulas.

Optional Feature:
Macro: SHIFT_CHAIN_COLLAPSE_MON_EN
- Defined:
  - Adds output collapsed_q [DEPTH-1:0]. It models the chain as if written with blocking assignments: every stage loads serial_in on each SHIFT/DRAIN edge.
  - Adds output diverge_cnt [7:0]. It increments (saturating at 255) on each SHIFT/DRAIN edge where the next collapsed_q[DEPTH-1] differs from the next stage_q[DEPTH-1].
  - Both outputs clear on reset and on accepted start.
  - For DEPTH=1, diverge_cnt stays 0.
- Undefined: neither port exists; core behaviour is identical.

Test Plan:
1. DEPTH=3, PAT_W=8, pattern=8'hA5, start pulse at edge E0 -> busy high E0..E11 (11 cycles); done=1 only in the cycle after E11; capture=8'hA5; stage_q=3'b000 when done=1.
2. Same run, probe stage_q[2] -> shows bits 1,0,1,0,0,1,0,1 after edges E3..E10 (pattern LSB first, latency 3).
3. start asserted continuously with pattern toggling during a run -> exactly one run per IDLE visit; capture equals the pattern latched at acceptance; next run accepted only after DONE->IDLE.
4. abort at edge E5 of a pattern=8'hFF run -> IDLE after E6, stage_q=0, no done pulse; capture holds its partial value; a new start runs normally.
5. rst pulsed asynchronously mid-DRAIN (between edges) -> all outputs 0 immediately, no done; a post-reset run with 8'h3C yields capture=8'h3C.
6. With SHIFT_CHAIN_COLLAPSE_MON_EN, DEPTH=3, pattern=8'b00000001 -> diverge_cnt=2 at done (collapsed last stage sees bit0 at E1 and 0 at E2, while the true chain sees it only at E3).
